decode_stage: RTL and testbench

- Registered RV32I/RV64I instruction decode stage with valid/ready handshake on both sides.
- Sits between fetch and register-read. Splits instruction fields, classifies format, generates sign-extended immediates, flags illegal encodings and register usage.
- Optional skid buffer so `in_ready` is a registered signal.
- Supports pipeline flush from the branch/exception logic.

---
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decode with a valid/ready
// handshake on both sides, an optional two-entry skid buffer and pipeline flush.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_INV = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
    } bundle_t;

    bundle_t            dec;
    bundle_t            m;
    bundle_t            s;
    logic               m_valid;
    logic               s_valid;
    logic               rdy_q;
    logic               acc;
    logic               is_sys;
    logic               is_fence;
    logic signed [31:0] imm32;

    // Combinational decode of the incoming instruction into a bundle.
    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.instr = in_instr;
        imm32     = '0;
        is_sys    = (in_instr[6:0] == 7'b1110011);
        is_fence  = (in_instr[6:0] == 7'b0001111);
        // Every legal opcode ends in 2'b11, so compressed encodings fall to INV.
        case (in_instr[6:0])
            7'b0110011:                         dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011:             dec.fmt = FMT_I;
            7'b0100011:                         dec.fmt = FMT_S;
            7'b1100011:                         dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
            7'b1101111:                         dec.fmt = FMT_J;
            default:                            dec.fmt = FMT_INV;
        endcase
        case (dec.fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm      = XLEN'(imm32);
        dec.illegal  = (dec.fmt == FMT_INV);
        dec.uses_rs1 = (dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) &&
                       !(is_sys && in_instr[14]);
        dec.uses_rs2 = (dec.fmt inside {FMT_R, FMT_S, FMT_B});
        dec.writes_rd = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                        (in_instr[11:7] != 5'd0) && !is_fence &&
                        !(is_sys && (in_instr[14:12] == 3'd0));
    end

    assign acc = in_valid && in_ready;

    // Main/skid register update: reset over flush over handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            s       <= '0;
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (!m_valid || out_ready) begin
            // M empty or draining: the skid entry has priority (in_ready was
            // low, so nothing new can arrive while it is occupied).
            if (s_valid) begin
                m       <= s;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                m_valid <= acc;
                if (acc) m <= dec;
            end
            rdy_q <= 1'b1;
        end else if (acc && (SKID != 0)) begin
            s       <= dec;
            s_valid <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= !s_valid;
        end
    end

    // Ready is forced low during reset so the upstream never sees an early accept.
    always_comb begin
        if (SKID != 0) in_ready = !rst && rdy_q;
        else           in_ready = !rst && (!m_valid || out_ready);
    end

    assign out_valid = m_valid;
    assign out_pc    = m.pc;
    assign opcode    = m.instr[6:0];
    assign rd        = m.instr[11:7];
    assign funct3    = m.instr[14:12];
    assign rs1       = m.instr[19:15];
    assign rs2       = m.instr[24:20];
    assign funct7    = m.instr[31:25];
    assign imm       = m.imm;
    assign fmt       = m.fmt;
    assign illegal   = m.illegal;
    assign uses_rs1  = m.uses_rs1;
    assign uses_rs2  = m.uses_rs2;
    assign writes_rd = m.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage (32-bit skid, 64-bit skid,
// 32-bit no-skid instances sharing one stimulus stream).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;

    logic        a_in_ready, a_out_valid, a_illegal, a_u1, a_u2, a_wr;
    logic [31:0] a_out_pc, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_fmt;

    logic        b_in_ready, b_out_valid, b_illegal, b_u1, b_u2, b_wr;
    logic [63:0] b_out_pc, b_imm;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_fmt;

    logic        c_in_ready, c_out_valid, c_illegal, c_u1, c_u2, c_wr;
    logic [31:0] c_out_pc, c_imm;
    logic [6:0]  c_opcode, c_funct7;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [2:0]  c_funct3, c_fmt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;
    assign in_pc64 = {32'd0, in_pc};

    decode_stage #(.XLEN(32), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .opcode(a_opcode), .rd(a_rd), .funct3(a_funct3), .rs1(a_rs1),
        .rs2(a_rs2), .funct7(a_funct7), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal),
        .uses_rs1(a_u1), .uses_rs2(a_u2), .writes_rd(a_wr));

    decode_stage #(.XLEN(64), .SKID(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc64), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1),
        .rs2(b_rs2), .funct7(b_funct7), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal),
        .uses_rs1(b_u1), .uses_rs2(b_u2), .writes_rd(b_wr));

    decode_stage #(.XLEN(32), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_pc(c_out_pc), .opcode(c_opcode), .rd(c_rd), .funct3(c_funct3), .rs1(c_rs1),
        .rs2(c_rs2), .funct7(c_funct7), .imm(c_imm), .fmt(c_fmt), .illegal(c_illegal),
        .uses_rs1(c_u1), .uses_rs2(c_u2), .writes_rd(c_wr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;

        // reset state
        tick(); tick();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_in_ready_noskid", c_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_fmt", a_fmt, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_out_pc", a_out_pc, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1);

        // addi x1,x0,-1
        offer(32'hFFF00093, 32'h100);
        tick();
        chk("addi_valid", a_out_valid, 1);
        chk("addi_fmt", a_fmt, 1);
        chk("addi_rd", a_rd, 1);
        chk("addi_rs1", a_rs1, 0);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_u1", a_u1, 1);
        chk("addi_wr", a_wr, 1);
        chk("addi_pc", a_out_pc, 32'h100);
        chk("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);

        // back-to-back sw / beq / lui
        offer(32'h0020A423, 32'h104);
        tick();
        chk("sw_valid", a_out_valid, 1);
        chk("sw_fmt", a_fmt, 2);
        chk("sw_imm", a_imm, 8);
        chk("sw_u2", a_u2, 1);
        chk("sw_wr", a_wr, 0);
        chk("sw_rs2", a_rs2, 2);
        chk("sw_pc", a_out_pc, 32'h104);
        offer(32'hFE000EE3, 32'h108);
        tick();
        chk("beq_valid", a_out_valid, 1);
        chk("beq_fmt", a_fmt, 3);
        chk("beq_imm", a_imm, 32'hFFFFFFFC);
        chk("beq_pc", a_out_pc, 32'h108);
        offer(32'h123452B7, 32'h10C);
        tick();
        chk("lui_valid", a_out_valid, 1);
        chk("lui_fmt", a_fmt, 4);
        chk("lui_imm", a_imm, 32'h12345000);
        chk("lui_rd", a_rd, 5);
        chk("lui_wr", a_wr, 1);
        chk("lui_pc", a_out_pc, 32'h10C);

        // illegal encodings
        offer(32'h00000000, 32'h110);
        tick();
        chk("ill0_illegal", a_illegal, 1);
        chk("ill0_fmt", a_fmt, 7);
        chk("ill0_imm", a_imm, 0);
        chk("ill0_flags", {a_u1, a_u2, a_wr}, 0);
        offer(32'h0000007F, 32'h114);
        tick();
        chk("ill7f_illegal", a_illegal, 1);
        chk("ill7f_fmt", a_fmt, 7);
        chk("ill7f_imm", a_imm, 0);
        chk("ill7f_flags", {a_u1, a_u2, a_wr}, 0);

        // lui x5,0x80000 (64-bit sign extension)
        offer(32'h800002B7, 32'h118);
        tick();
        chk("lui8_imm32", a_imm, 32'h80000000);
        chk("lui8_imm64", b_imm, 64'hFFFFFFFF80000000);

        // csrrwi x1: immediate form, no rs1 read, writes rd
        offer(32'h000050F3, 32'h11C);
        tick();
        chk("csrrwi_fmt", a_fmt, 1);
        chk("csrrwi_u1", a_u1, 0);
        chk("csrrwi_wr", a_wr, 1);

        // jal x1,+0x800
        offer(32'h001000EF, 32'h120);
        tick();
        chk("jal_fmt", a_fmt, 5);
        chk("jal_imm", a_imm, 32'h800);
        chk("jal_flags", {a_u1, a_u2, a_wr}, 3'b001);

        in_valid = 1'b0;
        tick();
        chk("idle_valid", a_out_valid, 0);

        // skid: hold downstream, offer three
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h200);
        tick();
        chk("skid_a_pc", a_out_pc, 32'h200);
        chk("skid_a_ready", a_in_ready, 1);
        chk("noskid_hold_ready", c_in_ready, 0);
        offer(32'h0020A423, 32'h204);
        tick();
        chk("skid_b_ready", a_in_ready, 0);
        chk("skid_b_pc_hold", a_out_pc, 32'h200);
        offer(32'h123452B7, 32'h208);
        tick();
        chk("skid_c_ready", a_in_ready, 0);
        chk("skid_c_valid", a_out_valid, 1);
        chk("skid_c_pc_hold", a_out_pc, 32'h200);
        chk("skid_c_fmt_hold", a_fmt, 1);
        out_ready = 1'b1;
        tick();
        chk("drain1_pc", a_out_pc, 32'h204);
        chk("drain1_fmt", a_fmt, 2);
        chk("drain1_ready", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("drain2_pc", a_out_pc, 32'h208);
        chk("drain2_valid", a_out_valid, 1);
        tick();
        chk("drain_empty", a_out_valid, 0);

        // flush with M and S full, plus an offered input
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h300);
        tick();
        offer(32'hFFF00093, 32'h304);
        tick();
        chk("fl_full_ready", a_in_ready, 0);
        offer(32'hFFF00093, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", a_out_valid, 0);
        chk("fl_ready", a_in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_valid2", a_out_valid, 0);

        // flush with an input accepted in the same cycle
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h30C);
        tick();
        offer(32'hFFF00093, 32'h310);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl_acc_valid", a_out_valid, 0);
        chk("fl_acc_ready", a_in_ready, 1);
        tick();
        chk("fl_acc_valid2", a_out_valid, 0);
        offer(32'h123452B7, 32'h400);
        tick();
        in_valid = 1'b0;
        chk("fl_recover_pc", a_out_pc, 32'h400);
        chk("fl_recover_valid", a_out_valid, 1);

        // reset while holding data
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h500);
        tick();
        in_valid = 1'b0;
        chk("hold_before_rst", a_out_valid, 1);
        rst = 1'b1;
        tick();
        chk("rst2_valid", a_out_valid, 0);
        chk("rst2_pc", a_out_pc, 0);
        chk("rst2_imm", a_imm, 0);
        chk("rst2_rd", a_rd, 0);
        chk("rst2_wr", a_wr, 0);
        chk("rst2_imm64", b_imm, 0);
        chk("rst2_ready", a_in_ready, 0);
        rst = 1'b0;
        tick();
        chk("rst2_after_valid", a_out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
